// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the fetch-stage sequencer.
package fetch_ctrl_pkg;

  localparam int unsigned DefAddrW   = 16;
  localparam int unsigned DefInstrW  = 16;
  localparam logic [15:0] DefResetPc = 16'h0000;
  localparam logic [15:0] DefNop     = 16'h0000;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain,
    StHalt
  } fetch_state_e;

  // States in which a memory request is being presented.
  function automatic logic state_has_req(fetch_state_e s);
    return (s == StFetch) || (s == StDrain);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory req/ack channel between the fetch stage and imem.
interface fetch_ctrl_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry buffer parking an instruction fetched while decode is stalled.
module fetch_hold_buf #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic               i_drain,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;

  // Clear (redirect/halt) wins over a same-cycle load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the imem handshake, and feeds IF/ID.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned        ADDR_W   = DefAddrW,
  parameter int unsigned        INSTR_W  = DefInstrW,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DefResetPc),
  parameter logic [INSTR_W-1:0] NOP      = INSTR_W'(DefNop)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hz_stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               halt,
  fetch_ctrl_if.master       imem,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               flush,
  output logic               halted
);

  fetch_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [ADDR_W-1:0]  r_drain_addr, w_drain_addr_nxt;
  logic               r_halt_pend, w_halt_pend_nxt;
  logic               r_ifid_valid, w_ifid_valid_nxt;
  logic [INSTR_W-1:0] r_ifid_instr, w_ifid_instr_nxt;
  logic [ADDR_W-1:0]  r_ifid_pc, w_ifid_pc_nxt;

  logic               w_req, w_ack, w_flush;
  logic               w_hb_load, w_hb_clear, w_hb_drain, w_hb_valid;
  logic [INSTR_W-1:0] w_hb_instr;
  logic [ADDR_W-1:0]  w_hb_pc;
  logic [ADDR_W-1:0]  w_pc_inc;

  assign w_req    = state_has_req(r_state);
  assign w_ack    = w_req & imem.imem_ack;
  assign w_pc_inc = r_pc + ADDR_W'(1);

  // While draining, the abandoned request keeps its original address.
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = (r_state == StDrain) ? r_drain_addr : r_pc;

  fetch_hold_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_hb_load),
    .i_clear (w_hb_clear),
    .i_drain (w_hb_drain),
    .i_instr (imem.imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_hb_valid),
    .o_instr (w_hb_instr),
    .o_pc    (w_hb_pc)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drain_addr_nxt = r_drain_addr;
    w_halt_pend_nxt  = r_halt_pend;
    w_ifid_valid_nxt = r_ifid_valid;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_hb_load        = 1'b0;
    w_hb_clear       = 1'b0;
    w_hb_drain       = 1'b0;
    w_flush          = 1'b0;

    case (r_state)
      StIdle: w_state_nxt = StFetch;

      StFetch: begin
        if (br_taken) begin
          w_flush          = 1'b1;
          w_pc_nxt         = br_target;
          w_ifid_valid_nxt = 1'b0;
          w_hb_clear       = 1'b1;
          w_halt_pend_nxt  = 1'b0;
          if (!w_ack) begin
            w_state_nxt      = StDrain;
            w_drain_addr_nxt = r_pc;
          end
        end else if (hz_stall) begin
          if (w_ack) begin
            w_hb_load   = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = StHold;
          end
        end else if (halt) begin
          w_ifid_valid_nxt = 1'b0;
          if (w_ack) begin
            w_state_nxt = StHalt;
          end else begin
            w_state_nxt      = StDrain;
            w_drain_addr_nxt = r_pc;
            w_halt_pend_nxt  = 1'b1;
          end
        end else if (w_ack) begin
          w_ifid_valid_nxt = 1'b1;
          w_ifid_instr_nxt = imem.imem_rdata;
          w_ifid_pc_nxt    = r_pc;
          w_pc_nxt         = w_pc_inc;
        end else begin
          w_ifid_valid_nxt = 1'b0;
        end
      end

      StHold: begin
        if (br_taken) begin
          w_flush          = 1'b1;
          w_pc_nxt         = br_target;
          w_ifid_valid_nxt = 1'b0;
          w_hb_clear       = 1'b1;
          w_halt_pend_nxt  = 1'b0;
          w_state_nxt      = StFetch;
        end else if (!hz_stall) begin
          if (halt) begin
            w_ifid_valid_nxt = 1'b0;
            w_hb_clear       = 1'b1;
            w_state_nxt      = StHalt;
          end else begin
            w_ifid_valid_nxt = w_hb_valid;
            w_ifid_instr_nxt = w_hb_instr;
            w_ifid_pc_nxt    = w_hb_pc;
            w_hb_drain       = 1'b1;
            w_state_nxt      = StFetch;
          end
        end
      end

      StDrain: begin
        if (br_taken) begin
          // The flush also kills any halt still sitting in ID, so drop the pending halt.
          w_flush          = 1'b1;
          w_pc_nxt         = br_target;
          w_ifid_valid_nxt = 1'b0;
          w_hb_clear       = 1'b1;
          w_halt_pend_nxt  = 1'b0;
          if (w_ack) w_state_nxt = StFetch;
        end else begin
          if (halt && !hz_stall) w_halt_pend_nxt = 1'b1;
          if (w_ack) begin
            w_halt_pend_nxt = 1'b0;
            w_state_nxt     = (r_halt_pend || (halt && !hz_stall)) ? StHalt : StFetch;
          end
        end
      end

      StHalt: w_ifid_valid_nxt = 1'b0;

      default: w_state_nxt = StIdle;
    endcase

    if (!w_ifid_valid_nxt) w_ifid_instr_nxt = NOP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
      r_halt_pend  <= 1'b0;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= NOP;
      r_ifid_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drain_addr <= w_drain_addr_nxt;
      r_halt_pend  <= w_halt_pend_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
    end
  end

  assign ifid_valid = r_ifid_valid;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc    = r_ifid_pc;
  assign flush      = w_flush;
  assign halted     = (r_state == StHalt);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a consumer-side scoreboard of fetched instructions.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hz_stall, br_taken, halt;
  logic [15:0] br_target;
  logic        ifid_valid, flush, halted;
  logic [15:0] ifid_instr, ifid_pc;
  logic        ack_tied, ack_man;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(16), .INSTR_W(16)) imem_if ();

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  assign imem_if.imem_ack   = ack_tied ? imem_if.imem_req : ack_man;
  assign imem_if.imem_rdata = mem_fn(imem_if.imem_addr);

  fetch_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .hz_stall   (hz_stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .halt       (halt),
    .imem       (imem_if),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .flush      (flush),
    .halted     (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [15:0] pc);
    sb_q.push_back({pc, mem_fn(pc)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode consumes IF/ID whenever it is live, not stalled and not being flushed.
  always @(negedge clk) begin
    if (!rst && ifid_valid && !hz_stall && !flush) begin
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) check_eq("sb_ifid", {ifid_pc, ifid_instr}, sb_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hz_stall = 1'b0; br_taken = 1'b0; br_target = '0; halt = 1'b0;
    ack_tied = 1'b0; ack_man = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check_eq("rst_req", imem_if.imem_req, 0);
    check_eq("rst_addr", imem_if.imem_addr, 16'h0000);
    check_eq("rst_valid", ifid_valid, 0);
    check_eq("rst_instr", ifid_instr, 16'h0000);
    check_eq("rst_pc", ifid_pc, 16'h0000);
    check_eq("rst_flush", flush, 0);
    check_eq("rst_halted", halted, 0);
    tick();

    // Zero-wait memory: one instruction per cycle.
    rst = 1'b0; ack_tied = 1'b1;
    @(negedge clk);
    check_eq("idle_req", imem_if.imem_req, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      sb_push(16'(i));
      @(negedge clk);
      check_eq("t1_addr", imem_if.imem_addr, i);
      check_eq("t1_req", imem_if.imem_req, 1);
      if (i > 0) check_eq("t1_ifid_pc", ifid_pc, i - 1);
      tick();
    end

    // Slow memory: ack two cycles after req at pc 5.
    ack_tied = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ack_man = (i == 2);
      if (i == 2) sb_push(16'h0005);
      @(negedge clk);
      check_eq("t2_addr", imem_if.imem_addr, 16'h0005);
      check_eq("t2_ifid_valid", ifid_valid, (i == 0));
      tick();
    end
    ack_man = 1'b1; sb_push(16'h0006);
    @(negedge clk);
    check_eq("t2_ifid_pc", ifid_pc, 16'h0005);
    check_eq("t2_ifid_valid_ack", ifid_valid, 1);
    check_eq("t2_addr_next", imem_if.imem_addr, 16'h0006);
    tick();

    // Decode stall for three cycles with an ack in the middle.
    for (int i = 0; i < 3; i++) begin
      hz_stall = 1'b1;
      ack_man  = (i == 1);
      if (i == 1) sb_push(16'h0007);
      @(negedge clk);
      check_eq("t3_ifid_pc", ifid_pc, 16'h0006);
      check_eq("t3_req", imem_if.imem_req, (i != 2));
      tick();
    end
    hz_stall = 1'b0; ack_man = 1'b0;
    @(negedge clk);
    check_eq("t3_ifid_pc_release", ifid_pc, 16'h0006);
    check_eq("t3_req_hold", imem_if.imem_req, 0);
    tick();
    @(negedge clk);
    check_eq("t3_ifid_pc_after", ifid_pc, 16'h0007);
    check_eq("t3_addr_after", imem_if.imem_addr, 16'h0008);
    check_eq("t3_req_after", imem_if.imem_req, 1);
    tick();

    // Redirect while the request to 8 is still unacked.
    br_taken = 1'b1; br_target = 16'h0100;
    @(negedge clk);
    check_eq("t4_flush", flush, 1);
    check_eq("t4_addr_br", imem_if.imem_addr, 16'h0008);
    check_eq("t4_ifid_valid", ifid_valid, 0);
    tick();
    br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ack_man = (i == 1);
      @(negedge clk);
      check_eq("t4_drain_addr", imem_if.imem_addr, 16'h0008);
      check_eq("t4_drain_req", imem_if.imem_req, 1);
      check_eq("t4_drain_flush", flush, 0);
      tick();
    end
    ack_man = 1'b1; sb_push(16'h0100);
    @(negedge clk);
    check_eq("t4_addr_target", imem_if.imem_addr, 16'h0100);
    check_eq("t4_dropped", ifid_valid, 0);
    tick();
    ack_man = 1'b0;
    @(negedge clk);
    check_eq("t4_ifid_pc", ifid_pc, 16'h0100);
    check_eq("t4_addr_seq", imem_if.imem_addr, 16'h0101);
    tick();

    // Redirect to FFFF with a same-cycle ack, then wrap.
    br_taken = 1'b1; br_target = 16'hFFFF; ack_man = 1'b1;
    @(negedge clk);
    check_eq("t5_flush", flush, 1);
    tick();
    br_taken = 1'b0; sb_push(16'hFFFF);
    @(negedge clk);
    check_eq("t5_addr_ffff", imem_if.imem_addr, 16'hFFFF);
    check_eq("t5_same_cycle_drop", ifid_valid, 0);
    tick();

    // Halt while the request to 0000 is outstanding.
    ack_man = 1'b0; halt = 1'b1;
    @(negedge clk);
    check_eq("t5_addr_wrap", imem_if.imem_addr, 16'h0000);
    check_eq("t5_ifid_pc", ifid_pc, 16'hFFFF);
    check_eq("t6_halted_early", halted, 0);
    tick();
    halt = 1'b0; ack_man = 1'b1;
    @(negedge clk);
    check_eq("t6_drain_req", imem_if.imem_req, 1);
    check_eq("t6_drain_addr", imem_if.imem_addr, 16'h0000);
    check_eq("t6_ifid_valid", ifid_valid, 0);
    tick();
    ack_man = 1'b0; br_target = 16'h0200;
    for (int i = 0; i < 20; i++) begin
      br_taken = (i == 5);
      halt     = (i == 9);
      ack_man  = (i == 12);
      @(negedge clk);
      check_eq("t6_halted", halted, 1);
      check_eq("t6_req", imem_if.imem_req, 0);
      check_eq("t6_valid", ifid_valid, 0);
      check_eq("t6_flush", flush, 0);
      tick();
    end

    // Reset out of HALT.
    rst = 1'b1; br_taken = 1'b0; halt = 1'b0; ack_man = 1'b0;
    tick();
    @(negedge clk);
    check_eq("t6_rst_req", imem_if.imem_req, 0);
    check_eq("t6_rst_addr", imem_if.imem_addr, 16'h0000);
    check_eq("t6_rst_valid", ifid_valid, 0);
    check_eq("t6_rst_halted", halted, 0);
    tick();
    rst = 1'b0; ack_tied = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      sb_push(16'(i));
      @(negedge clk);
      check_eq("t7_addr", imem_if.imem_addr, i);
      tick();
    end
    ack_tied = 1'b0;
    tick();
    @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
